// File: rtl/td4x_pkg.sv
// td4x_pkg: shared definitions for the td4x accumulator CPU.
//   - 4-bit opcode constants (OP_ADD_A .. OP_RET)
//   - run/halt state enum
//   - opcode-field helpers used by the core decode
package td4x_pkg;

    localparam logic [3:0] OP_ADD_A  = 4'b0000;
    localparam logic [3:0] OP_MOV_AB = 4'b0001;  // A = B
    localparam logic [3:0] OP_IN_A   = 4'b0010;
    localparam logic [3:0] OP_MOV_A  = 4'b0011;  // A = imm
    localparam logic [3:0] OP_MOV_BA = 4'b0100;  // B = A
    localparam logic [3:0] OP_ADD_B  = 4'b0101;
    localparam logic [3:0] OP_IN_B   = 4'b0110;
    localparam logic [3:0] OP_MOV_B  = 4'b0111;  // B = imm
    localparam logic [3:0] OP_HALT   = 4'b1000;
    localparam logic [3:0] OP_OUT_B  = 4'b1001;
    localparam logic [3:0] OP_JC     = 4'b1010;
    localparam logic [3:0] OP_OUT_I  = 4'b1011;
    localparam logic [3:0] OP_CALL   = 4'b1100;
    localparam logic [3:0] OP_RET    = 4'b1101;
    localparam logic [3:0] OP_JNC    = 4'b1110;
    localparam logic [3:0] OP_JMP    = 4'b1111;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } state_e;

    // Branch decision for the three jump opcodes; c is the carry from
    // before the executing edge.
    function automatic logic jump_taken(input logic [3:0] op, input logic c);
        case (op)
            OP_JMP:  return 1'b1;
            OP_JNC:  return !c;
            OP_JC:   return c;
            default: return 1'b0;
        endcase
    endfunction

    // True for the two opcodes that load carry from the adder.
    function automatic logic is_add(input logic [3:0] op);
        return (op == OP_ADD_A) || (op == OP_ADD_B);
    endfunction

endpackage

// File: rtl/td4x_call_stack.sv
// td4x_call_stack: DEPTH-entry LIFO of return addresses.
// Ports:
//   clk_i, rst_ni    clock, asynchronous active-low reset (empties the stack)
//   push_i           write push_data_i on top (ignored when full)
//   pop_i            discard the top entry (ignored when empty)
//   push_data_i      address to push
//   top_o            current top entry (valid when !empty_o)
//   full_o, empty_o  occupancy flags
module td4x_call_stack #(
    parameter int ADDR_W = 4,
    parameter int DEPTH  = 4
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              push_i,
    input  logic              pop_i,
    input  logic [ADDR_W-1:0] push_data_i,
    output logic [ADDR_W-1:0] top_o,
    output logic              full_o,
    output logic              empty_o
);

    localparam int SP_W  = $clog2(DEPTH + 1);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [SP_W-1:0]   sp_q;
    logic [ADDR_W-1:0] mem_q [DEPTH];
    logic [IDX_W-1:0]  wr_idx;
    logic [IDX_W-1:0]  rd_idx;

    assign full_o  = (sp_q == SP_W'(DEPTH));
    assign empty_o = (sp_q == '0);
    // sp_q counts entries, so the next free slot is sp_q and the top is sp_q-1.
    assign wr_idx  = IDX_W'(sp_q);
    assign rd_idx  = IDX_W'(sp_q - 1'b1);
    assign top_o   = mem_q[rd_idx];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sp_q <= '0;
        end else if (push_i && !full_o) begin
            sp_q <= sp_q + 1'b1;
        end else if (pop_i && !empty_o) begin
            sp_q <= sp_q - 1'b1;
        end
    end

    // Storage needs no reset: entries are only read below the pointer.
    always_ff @(posedge clk_i) begin
        if (push_i && !full_o) begin
            mem_q[wr_idx] <= push_data_i;
        end
    end

endmodule

// File: rtl/td4x_core.sv
// td4x_core: single-cycle accumulator CPU (parametrised TD4 successor).
// Optional CALL/RET return stack enabled by defining TD4X_CALL_STACK_EN.
// Ports:
//   CLK         rising-edge clock
//   CLR         asynchronous active-low reset
//   EN          clock enable; 0 freezes all state
//   resume      leaves HALT when sampled 1 with EN=1
//   instr       ROM word: [DATA_W+3:DATA_W] opcode, [DATA_W-1:0] imm
//   instr_addr  PC, drives the external ROM address
//   in_port     input port
//   out_port    output port register
//   carry       carry flag
//   halted      1 while in HALT (the FSM state itself)
//   stack_err   sticky stack overflow/underflow (0 without the stack)
module td4x_core
    import td4x_pkg::*;
#(
    parameter int DATA_W      = 4,
    parameter int ADDR_W      = 4,
    parameter int STACK_DEPTH = 4
) (
    input  logic              CLK,
    input  logic              CLR,
    input  logic              EN,
    input  logic              resume,
    input  logic [DATA_W+3:0] instr,
    output logic [ADDR_W-1:0] instr_addr,
    input  logic [DATA_W-1:0] in_port,
    output logic [DATA_W-1:0] out_port,
    output logic              carry,
    output logic              halted,
    output logic              stack_err
);

    // Jump targets are sliced from imm, so imm must be at least as wide as the PC.
    if (DATA_W < ADDR_W || STACK_DEPTH < 1) begin : g_bad_params
    end

    logic [ADDR_W-1:0] pc_q;
    logic [DATA_W-1:0] a_q;
    logic [DATA_W-1:0] b_q;
    logic [DATA_W-1:0] out_q;
    logic              carry_q;
    logic              halted_q;
    state_e            state_q;

    logic [3:0]        opcode;
    logic [DATA_W-1:0] imm;
    logic [ADDR_W-1:0] tgt;
    logic [ADDR_W-1:0] pc_inc;
    logic [DATA_W:0]   sum_a;
    logic [DATA_W:0]   sum_b;

    assign opcode = instr[DATA_W+3:DATA_W];
    assign imm    = instr[DATA_W-1:0];
    assign tgt    = imm[ADDR_W-1:0];
    assign pc_inc = pc_q + 1'b1;
    assign sum_a  = {1'b0, a_q} + {1'b0, imm};
    assign sum_b  = {1'b0, b_q} + {1'b0, imm};

`ifdef TD4X_CALL_STACK_EN
    logic              err_q;
    logic              stk_push;
    logic              stk_pop;
    logic              stk_full;
    logic              stk_empty;
    logic [ADDR_W-1:0] stk_top;

    assign stk_push = EN && (state_q == ST_RUN) && (opcode == OP_CALL) && !stk_full;
    assign stk_pop  = EN && (state_q == ST_RUN) && (opcode == OP_RET) && !stk_empty;

    td4x_call_stack #(
        .ADDR_W (ADDR_W),
        .DEPTH  (STACK_DEPTH)
    ) u_call_stack (
        .clk_i       (CLK),
        .rst_ni      (CLR),
        .push_i      (stk_push),
        .pop_i       (stk_pop),
        .push_data_i (pc_inc),
        .top_o       (stk_top),
        .full_o      (stk_full),
        .empty_o     (stk_empty)
    );

    assign stack_err = err_q;
`else
    assign stack_err = 1'b0;
`endif

    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR) begin
            pc_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            out_q    <= '0;
            carry_q  <= 1'b0;
            halted_q <= 1'b0;
            state_q  <= ST_RUN;
`ifdef TD4X_CALL_STACK_EN
            err_q    <= 1'b0;
`endif
        end else if (EN) begin
            case (state_q)
                ST_RUN: begin
                    // Every non-ADD instruction clears carry; default is sequential fetch.
                    carry_q <= 1'b0;
                    pc_q    <= pc_inc;
                    case (opcode)
                        OP_ADD_A:  {carry_q, a_q} <= sum_a;
                        OP_ADD_B:  {carry_q, b_q} <= sum_b;
                        OP_MOV_A:  a_q   <= imm;
                        OP_MOV_B:  b_q   <= imm;
                        OP_MOV_AB: a_q   <= b_q;
                        OP_MOV_BA: b_q   <= a_q;
                        OP_IN_A:   a_q   <= in_port;
                        OP_IN_B:   b_q   <= in_port;
                        OP_OUT_B:  out_q <= b_q;
                        OP_OUT_I:  out_q <= imm;
                        OP_JMP, OP_JNC, OP_JC: begin
                            if (jump_taken(opcode, carry_q)) pc_q <= tgt;
                        end
                        OP_HALT: begin
                            pc_q     <= pc_q;
                            state_q  <= ST_HALT;
                            halted_q <= 1'b1;
                        end
`ifdef TD4X_CALL_STACK_EN
                        // Stack faults park the CPU on the offending instruction.
                        OP_CALL: begin
                            if (stk_full) begin
                                pc_q     <= pc_q;
                                err_q    <= 1'b1;
                                state_q  <= ST_HALT;
                                halted_q <= 1'b1;
                            end else begin
                                pc_q <= tgt;
                            end
                        end
                        OP_RET: begin
                            if (stk_empty) begin
                                pc_q     <= pc_q;
                                err_q    <= 1'b1;
                                state_q  <= ST_HALT;
                                halted_q <= 1'b1;
                            end else begin
                                pc_q <= stk_top;
                            end
                        end
`endif
                        default: ;
                    endcase
                end
                ST_HALT: begin
                    // Resume only steps past the HALT; nothing executes this cycle.
                    if (resume) begin
                        pc_q     <= pc_inc;
                        state_q  <= ST_RUN;
                        halted_q <= 1'b0;
                    end
                end
            endcase
        end
    end

    assign instr_addr = pc_q;
    assign out_port   = out_q;
    assign carry      = carry_q;
    assign halted     = halted_q;

endmodule

// File: tb/tb_td4x_core.sv
module tb_td4x_core;

  localparam int SD = 2;

  // ---------------- clock / reset ----------------
  logic CLK = 1'b0;
  logic CLR = 1'b0;
  logic EN = 1'b0;
  logic resume = 1'b0;
  logic [7:0] in_port = '0;
  bit chk_on = 1'b0;

  always #5 CLK = ~CLK;

  // ---------------- ROMs and DUTs ----------------
  logic [7:0]  rom4 [16];
  logic [11:0] rom8 [64];

  logic [7:0]  instr4;
  logic [3:0]  addr4;
  logic [3:0]  out4;
  logic        c4, h4, e4;
  logic [11:0] instr8;
  logic [5:0]  addr8;
  logic [7:0]  out8;
  logic        c8, h8, e8;

  assign instr4 = rom4[addr4];
  assign instr8 = rom8[addr8];

  td4x_core #(.DATA_W(4), .ADDR_W(4), .STACK_DEPTH(SD)) dut4 (
    .CLK(CLK), .CLR(CLR), .EN(EN), .resume(resume), .instr(instr4),
    .instr_addr(addr4), .in_port(in_port[3:0]), .out_port(out4),
    .carry(c4), .halted(h4), .stack_err(e4)
  );

  td4x_core #(.DATA_W(8), .ADDR_W(6), .STACK_DEPTH(SD)) dut8 (
    .CLK(CLK), .CLR(CLR), .EN(EN), .resume(resume), .instr(instr8),
    .instr_addr(addr8), .in_port(in_port), .out_port(out8),
    .carry(c8), .halted(h8), .stack_err(e8)
  );

  // ---------------- behavioural model (index 0: 4/4, index 1: 8/6) ----------------
  int m_pc[2], m_a[2], m_b[2], m_out[2], m_c[2], m_h[2], m_err[2], m_sp[2];
  int m_stk[2][8];

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_pc[k] = 0; m_a[k] = 0; m_b[k] = 0; m_out[k] = 0;
      m_c[k] = 0; m_h[k] = 0; m_err[k] = 0; m_sp[k] = 0;
    end
  endtask

  task automatic model_step(input int k, input int dw, input int aw);
    int dm, am, w, op, imm, npc, oc, s;
    dm = (1 << dw) - 1;
    am = (1 << aw) - 1;
    if (!EN) return;
    if (m_h[k] != 0) begin
      if (resume) begin
        m_pc[k] = (m_pc[k] + 1) & am;
        m_h[k] = 0;
      end
      return;
    end
    w = (k == 0) ? int'(rom4[m_pc[0]]) : int'(rom8[m_pc[1]]);
    op = (w >> dw) & 15;
    imm = w & dm;
    npc = (m_pc[k] + 1) & am;
    oc = m_c[k];
    m_c[k] = 0;
    case (op)
      0:  begin s = m_a[k] + imm; m_a[k] = s & dm; m_c[k] = s >> dw; end
      5:  begin s = m_b[k] + imm; m_b[k] = s & dm; m_c[k] = s >> dw; end
      3:  m_a[k] = imm;
      7:  m_b[k] = imm;
      1:  m_a[k] = m_b[k];
      4:  m_b[k] = m_a[k];
      2:  m_a[k] = int'(in_port) & dm;
      6:  m_b[k] = int'(in_port) & dm;
      9:  m_out[k] = m_b[k];
      11: m_out[k] = imm;
      15: npc = imm & am;
      14: if (oc == 0) npc = imm & am;
      10: if (oc != 0) npc = imm & am;
      8:  begin m_h[k] = 1; npc = m_pc[k]; end
`ifdef TD4X_CALL_STACK_EN
      12: begin
        if (m_sp[k] == SD) begin
          m_err[k] = 1; m_h[k] = 1; npc = m_pc[k];
        end else begin
          m_stk[k][m_sp[k]] = npc;
          m_sp[k]++;
          npc = imm & am;
        end
      end
      13: begin
        if (m_sp[k] == 0) begin
          m_err[k] = 1; m_h[k] = 1; npc = m_pc[k];
        end else begin
          m_sp[k]--;
          npc = m_stk[k][m_sp[k]];
        end
      end
`endif
      default: ;
    endcase
    m_pc[k] = npc;
  endtask

  always @(posedge CLK) begin
    if (CLR) begin
      model_step(0, 4, 4);
      model_step(1, 8, 6);
    end
  end

  always @(negedge CLR) model_reset();

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge CLK) begin
    if (chk_on) begin
      check("pc4", 32'(addr4), m_pc[0]);
      check("out4", 32'(out4), m_out[0]);
      check("carry4", 32'(c4), m_c[0]);
      check("halted4", 32'(h4), m_h[0]);
      check("err4", 32'(e4), m_err[0]);
      check("pc8", 32'(addr8), m_pc[1]);
      check("out8", 32'(out8), m_out[1]);
      check("carry8", 32'(c8), m_c[1]);
      check("halted8", 32'(h8), m_h[1]);
      check("err8", 32'(e8), m_err[1]);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_cyc(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic assert_rst();
    @(negedge CLK);
    #2 CLR = 1'b0;
  endtask

  task automatic release_rst();
    @(negedge CLK);
    #2 CLR = 1'b1;
  endtask

  task automatic fill_default();
    for (int i = 0; i < 16; i++) rom4[i] = 8'h30;
    for (int i = 0; i < 64; i++) rom8[i] = 12'h300;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    model_reset();
    fill_default();
    CLR = 1'b0;
    EN = 1'b1;
    chk_on = 1'b1;
    wait_cyc(2);
    check("rst_pc4", 32'(addr4), 0);
    check("rst_out4", 32'(out4), 0);
    check("rst_carry4", 32'(c4), 0);
    check("rst_halted4", 32'(h4), 0);
    check("rst_err4", 32'(e4), 0);
    check("rst_pc8", 32'(addr8), 0);

    // Directed program: ADD carry, conditional jumps, I/O, PC wrap.
    rom4[0] = 8'h3E; rom4[1] = 8'h03; rom4[2] = 8'h70; rom4[3] = 8'h40;
    rom4[4] = 8'h90; rom4[5] = 8'h0F; rom4[6] = 8'hE9; rom4[7] = 8'h0F;
    rom4[8] = 8'hEA; rom4[10] = 8'h0F; rom4[11] = 8'hAD;
    rom4[13] = 8'h62; rom4[14] = 8'h90; rom4[15] = 8'h35;
    // Wide build: 0x01 + 0xFF wraps, JMP 0xFA lands on 0x3A.
    rom8[0] = 12'h301; rom8[1] = 12'h0FF; rom8[2] = 12'hFFA;
    rom8[58] = 12'h005; rom8[59] = 12'h400; rom8[60] = 12'h900;
    in_port = 8'h05;
    release_rst();
    wait_cyc(2);
    check("add_carry4", 32'(c4), 1);
    check("add_carry8", 32'(c8), 1);
    wait_cyc(1);
    check("mov_clr_carry4", 32'(c4), 0);
    check("jmp_wide_pc8", 32'(addr8), 32'h3A);
    wait_cyc(2);
    check("add_result_out4", 32'(out4), 1);
    wait_cyc(1);
    check("wrap_add_out8", 32'(out8), 5);
    wait_cyc(1);
    check("jnc_not_taken", 32'(addr4), 7);
    wait_cyc(2);
    check("jnc_taken", 32'(addr4), 32'hA);
    wait_cyc(2);
    check("jc_taken", 32'(addr4), 32'hD);
    wait_cyc(2);
    check("in_out_b", 32'(out4), 5);
    wait_cyc(1);
    check("pc_wrap", 32'(addr4), 0);

    // HALT / EN / resume / reset-in-HALT.
    assert_rst();
    fill_default();
    rom4[0] = 8'hBA; rom4[4] = 8'h3F; rom4[5] = 8'h01;
    rom4[6] = 8'h80; rom4[7] = 8'h80;
    release_rst();
    wait_cyc(7);
    check("halt_flag", 32'(h4), 1);
    check("halt_pc", 32'(addr4), 6);
    check("halt_carry", 32'(c4), 0);
    check("halt_out", 32'(out4), 32'hA);
    wait_cyc(10);
    check("halt_hold_pc", 32'(addr4), 6);
    check("halt_hold_flag", 32'(h4), 1);
    EN = 1'b0;
    resume = 1'b1;
    wait_cyc(1);
    check("resume_en0", 32'(h4), 1);
    EN = 1'b1;
    wait_cyc(1);
    check("resume_pc", 32'(addr4), 7);
    check("resume_flag", 32'(h4), 0);
    resume = 1'b0;
    wait_cyc(1);
    check("rehalt", 32'(h4), 1);
    #2 CLR = 1'b0;
    wait_cyc(1);
    check("clr_halt_pc", 32'(addr4), 0);
    check("clr_halt_flag", 32'(h4), 0);
    check("clr_halt_out", 32'(out4), 0);

`ifdef TD4X_CALL_STACK_EN
    // CALL/RET, overflow, underflow.
    fill_default();
    rom4[1] = 8'hC4; rom4[2] = 8'hC6; rom4[4] = 8'hD0;
    rom4[6] = 8'hC7; rom4[7] = 8'hC8;
    release_rst();
    wait_cyc(2);
    check("call_pc", 32'(addr4), 4);
    wait_cyc(1);
    check("ret_pc", 32'(addr4), 2);
    wait_cyc(3);
    check("ovf_pc", 32'(addr4), 7);
    check("ovf_err", 32'(e4), 1);
    check("ovf_halt", 32'(h4), 1);
    assert_rst();
    wait_cyc(1);
    check("err_cleared", 32'(e4), 0);
    rom4[0] = 8'hD0;
    release_rst();
    wait_cyc(1);
    check("unf_err", 32'(e4), 1);
    check("unf_pc", 32'(addr4), 0);
    assert_rst();
`endif

    // Randomized programs and inputs against the model.
    for (int blk = 0; blk < 10; blk++) begin
      for (int i = 0; i < 16; i++) rom4[i] = 8'($urandom);
      for (int i = 0; i < 64; i++) rom8[i] = 12'($urandom);
      release_rst();
      repeat (300) begin
        @(negedge CLK);
        EN = ($urandom_range(0, 9) != 0);
        resume = ($urandom_range(0, 3) == 0);
        in_port = 8'($urandom);
        if ($urandom_range(0, 199) == 0) begin
          #2 CLR = 1'b0;
          #2 CLR = 1'b1;
        end
      end
      assert_rst();
      EN = 1'b1;
      resume = 1'b0;
    end

    wait_cyc(2);
    chk_on = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/td4x_core.md
Name: td4x_core

Overview:
- Parametrised successor to the fixed 4-bit TD4 datapath: single-cycle accumulator CPU with A/B registers, output port register, PC and carry flag.
- Data width and program-address width are configurable; instruction ROM is external.
- Adds a clock-enable, a HALT/resume state machine, a JC instruction, and an optional CALL/RET stack.
- Instantiated by the CPU top beside the program ROM.

Parameters:
DATA_W, 4, width of A, B, immediate, in/out ports; must be >= ADDR_W
ADDR_W, 4, PC / instruction-address width; program depth 2**ADDR_W
STACK_DEPTH, 4, return-stack entries (used only with TD4X_CALL_STACK_EN)

Ports:
CLK  input  1  rising-edge clock
CLR  input  1  asynchronous active-low reset
EN  input  1  clock enable; 0 freezes all state
resume  input  1  leaves HALT when sampled 1 with EN=1
instr  input  DATA_W+4  instruction word from ROM: [DATA_W+3:DATA_W]=opcode, [DATA_W-1:0]=imm
instr_addr  output  ADDR_W  PC, drives ROM address
in_port  input  DATA_W  input port
out_port  output  DATA_W  output port register
carry  output  1  carry flag
halted  output  1  1 in HALT state
stack_err  output  1  sticky: stack overflow/underflow (0 when macro off)

Behaviour:
- Reset (CLR=0, async): PC, A, B, out_port, carry = 0; state RUN; stack pointer 0; stack_err = 0.
- Execution: ROM is combinational on instr_addr. Each rising CLK with EN=1 in RUN executes instr and updates all state in that one cycle. EN=0: nothing changes.
- Opcodes:
  - 0000 ADD A,imm: {c,A}=A+imm
  - 0101 ADD B,imm: {c,B}=B+imm
  - 0011 MOV A,imm
  - 0111 MOV B,imm
  - 0001 MOV A,B
  - 0100 MOV B,A
  - 0010 IN A: A=in_port
  - 0110 IN B: B=in_port
  - 1001 OUT B: out_port=B
  - 1011 OUT imm: out_port=imm
  - 1111 JMP imm
  - 1110 JNC imm: jump if carry==0
  - 1010 JC imm: jump if carry==1
  - 1000 HALT
  - 1100 CALL imm (macro only)
  - 1101 RET (macro only)
  - All other opcodes: NOP.
- Arithmetic: ADD is DATA_W-bit modulo; carry = bit DATA_W of the sum.
- Carry update: ADD loads carry. Every other executed instruction, including jumps and NOP, clears carry to 0. JNC/JC test the carry value from before the edge.
- Jumps: target = imm[ADDR_W-1:0]. Otherwise PC = PC+1, modulo 2**ADDR_W (wraps from all-ones to 0).
- State machine:
  - RUN -> HALT on executing 1000. PC stays on the HALT address; carry cleared.
  - In HALT, EN=1 and resume=1 -> PC=PC+1, RUN. No instruction executes that cycle.
  - resume is ignored in RUN. In HALT, A/B/out_port/carry hold.
  - halted = (state==HALT), registered.
- Reset mid-operation (any state) returns immediately to reset values.

Optional Feature:
- Macro: TD4X_CALL_STACK_EN.
- Defined:
  - STACK_DEPTH x ADDR_W LIFO.
  - CALL pushes PC+1 (wrapped) and jumps to imm.
  - RET pops into PC.
  - CALL when full or RET when empty: no push/pop, stack_err set (sticky until reset), state -> HALT, PC holds.
  - CALL/RET clear carry.
- Undefined: 1100/1101 are NOPs; stack_err tied 0; STACK_DEPTH unused.

Decomposition:
- Package td4x_pkg:
  - 4-bit opcode localparams OP_ADD_A … OP_RET
  - state enum {ST_RUN, ST_HALT}
  - opcode-field helpers
- One sub-module: td4x_call_stack (push/pop/full/empty/top, ADDR_W × STACK_DEPTH), instantiated only under the macro.
- ALU and decode stay inline in td4x_core.

Test Plan:
- Reset/ADD carry (DATA_W=4): MOV A,0xE; ADD A,0x3 -> A=0x1, carry=1. Next MOV B,0x0 -> carry=0.
- Conditional jumps: ADD A,0xF with A=1 (carry=1); JNC 0x9 -> PC=PC+1; JC 0x9 -> PC=0x9. Repeat with carry=0 -> opposite outcomes.
- I/O and wrap: in_port=0x5; IN B; OUT B -> out_port=0x5. Run NOPs from PC=0xF -> instr_addr=0x0.
- HALT/EN: HALT at 0x6 -> halted=1, PC=0x6, held for 10 cycles. resume with EN=0 -> still halted. resume with EN=1 -> PC=0x7, halted=0. Assert CLR low mid-HALT -> all outputs 0, RUN.
- Widths: DATA_W=8, ADDR_W=6. ADD A,0xFF on A=0x01 -> A=0x00, carry=1. JMP 0xFA -> PC=0x3A.
- Macro on, STACK_DEPTH=2:
  - CALL 0x4 at 0x1 -> PC=0x4; RET -> PC=0x2.
  - Three nested CALLs -> third leaves PC unchanged, stack_err=1, halted=1.
  - RET on empty stack after reset -> stack_err=1.
